// File: rtl/text_ram_writer.sv
// text_ram_writer: writer side of the 32x32 text-cell RAM scanned by the display.
// Consumes a valid/ready byte stream and keeps a cursor. Printable bytes are
// written at {row,col}. CR, LF, BS and FF move the cursor; FF also clears the
// screen. Optional build macro TEXT_RAM_WRITER_LINE_CLEAR_EN blanks every row
// the cursor moves into (LF or line wrap).
module text_ram_writer #(
  parameter int         COL_BITS = 5,
  parameter int         ROW_BITS = 5,
  parameter logic [7:0] FILL     = 8'h00
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [7:0]                   in_data,
  output logic                         in_ready,
  output logic [COL_BITS+ROW_BITS-1:0] ram_addr,
  output logic [7:0]                   ram_din,
  output logic                         ram_we,
  output logic [ROW_BITS-1:0]          cursor_row,
  output logic [COL_BITS-1:0]          cursor_col,
  output logic                         busy
);

  localparam int ADDR_BITS = COL_BITS + ROW_BITS;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1
`ifdef TEXT_RAM_WRITER_LINE_CLEAR_EN
    , S_LINECLR = 2'd2
`endif
  } state_t;

  state_t                state_q;
  // One extra MSB marks "all cells written"; the state leaves on the cycle
  // after the last write so in_ready stays low while that write is presented.
  logic [ADDR_BITS:0]    clr_cnt_q;
  logic [ROW_BITS-1:0]   cursor_row_q;
  logic [COL_BITS-1:0]   cursor_col_q;
  logic                  ram_we_q;
  logic [ADDR_BITS-1:0]  ram_addr_q;
  logic [7:0]            ram_din_q;

  logic [ROW_BITS-1:0]   cursor_row_d;
  logic [COL_BITS-1:0]   cursor_col_d;
  logic                  is_ctrl;
  logic                  accept;

  assign in_ready   = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign accept     = in_valid && in_ready;
  assign ram_we     = ram_we_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign cursor_row = cursor_row_q;
  assign cursor_col = cursor_col_q;

  // Decode the incoming byte into the cursor position it leads to.
  always_comb begin
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    is_ctrl      = 1'b1;
    case (in_data)
      CH_CR: cursor_col_d = '0;
      CH_LF: begin
        cursor_col_d = '0;
        cursor_row_d = cursor_row_q + 1'b1;
      end
      CH_BS: begin
        if (cursor_col_q != '0) begin
          cursor_col_d = cursor_col_q - 1'b1;
        end
      end
      CH_FF: begin
        cursor_col_d = '0;
        cursor_row_d = '0;
      end
      default: begin
        is_ctrl      = 1'b0;
        cursor_col_d = cursor_col_q + 1'b1;
        if (cursor_col_q == '1) begin
          cursor_row_d = cursor_row_q + 1'b1;
        end
      end
    endcase
  end

`ifdef TEXT_RAM_WRITER_LINE_CLEAR_EN
  // FF homes the cursor but is covered by the full clear, so it is excluded.
  logic row_change;
  assign row_change = (cursor_row_d != cursor_row_q) && (in_data != CH_FF);
`endif

  // Control FSM with registered RAM write port and cursor.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_din_q    <= 8'h00;
    end else begin
      ram_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cursor_row_q <= cursor_row_d;
            cursor_col_q <= cursor_col_d;
            if (in_data == CH_FF) begin
              state_q   <= S_CLEAR;
              clr_cnt_q <= '0;
            end else if (!is_ctrl) begin
              ram_we_q   <= 1'b1;
              ram_addr_q <= {cursor_row_q, cursor_col_q};
              ram_din_q  <= in_data;
            end
`ifdef TEXT_RAM_WRITER_LINE_CLEAR_EN
            if (row_change) begin
              state_q   <= S_LINECLR;
              clr_cnt_q <= '0;
            end
`endif
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q[ADDR_BITS]) begin
            state_q <= S_IDLE;
          end else begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= clr_cnt_q[ADDR_BITS-1:0];
            ram_din_q  <= FILL;
            clr_cnt_q  <= clr_cnt_q + 1'b1;
          end
        end
`ifdef TEXT_RAM_WRITER_LINE_CLEAR_EN
        S_LINECLR: begin
          // cursor_row_q already holds the row that was just entered.
          if (clr_cnt_q[COL_BITS]) begin
            state_q <= S_IDLE;
          end else begin
            ram_we_q   <= 1'b1;
            ram_addr_q <= {cursor_row_q, clr_cnt_q[COL_BITS-1:0]};
            ram_din_q  <= FILL;
            clr_cnt_q  <= clr_cnt_q + 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/text_ram_writer.md
Name: text_ram_writer

Overview:
- Writer side of the 32x32 text-cell RAM that the text display scans out.
- Accepts a byte stream over a valid/ready handshake and keeps a cursor.
- Writes printable bytes into RAM at address {row,col}, the same mapping the display reads.
- Interprets a small set of control codes: CR, LF, BS, FF (clear screen).

Parameters:
- COL_BITS, 5, log2 of columns per row (32).
- ROW_BITS, 5, log2 of rows (32).
- FILL, 8'h00, byte written by clear operations.

Ports:
- clk  input  1  system clock (display pixel clock domain).
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_data  input  8  character or control byte.
- in_ready  output  1  block can accept a byte this cycle.
- ram_addr  output  COL_BITS+ROW_BITS  RAM write address, {row,col}.
- ram_din  output  8  RAM write data.
- ram_we  output  1  RAM write enable, one-cycle pulses.
- cursor_row  output  ROW_BITS  current cursor row.
- cursor_col  output  COL_BITS  current cursor column.
- busy  output  1  a clear is in progress.

Behaviour:
- Reset (reset==0 at posedge clk):
  - state=CLEAR, clear counter=0, cursor=(0,0).
  - ram_we=0, ram_addr=0, ram_din=0.
  - in_ready=0, busy=1.
- in_ready = (state==IDLE), combinational from state.
- A byte transfers on a posedge where in_valid && in_ready.
- States:
  - IDLE: accepts one byte per cycle. Back-to-back transfers are allowed with no bubble.
  - CLEAR: full-screen clear.
  - LINECLR: only when LINE_CLEAR_EN is defined.
- Printable byte (any value except 0x08, 0x0A, 0x0C, 0x0D):
  - Next cycle: ram_we=1, ram_addr={row,col}, ram_din=in_data.
  - Cursor advances on the same edge: col+1.
  - At col 31 the cursor wraps to col 0, row+1. Row wraps 31->0.
- Control bytes never write RAM:
  - 0x0D CR: col=0.
  - 0x0A LF: col=0, row+1 (row wraps 31->0).
  - 0x08 BS: if col>0 then col-1; at col 0, no change.
  - 0x0C FF: cursor=(0,0), enter CLEAR with counter=0.
- CLEAR:
  - Runs 2^(ROW_BITS+COL_BITS) = 1024 cycles.
  - Each cycle: ram_we=1, ram_addr=counter, ram_din=FILL, counter+1.
  - After the write at address 1023, returns to IDLE; the next cycle has ram_we=0 and in_ready=1.
  - in_ready=0 and busy=1 throughout.
- ram_we is 0 in every cycle that does not follow a printable transfer and is not a clear-write cycle.
- Reset asserted mid-clear: the clear restarts from address 0. No partial state survives.
- in_valid held high while not ready: the byte is held by the source and not consumed. The block never drops or duplicates a byte.
- All counters and cursor arithmetic are modulo their field widths. No carry from col into row except the defined wrap rule.

Optional Feature:
- Macro: TEXT_RAM_WRITER_LINE_CLEAR_EN.
- Defined:
  - Whenever the cursor moves to a new row, the block enters LINECLR on the following cycle. This covers LF and printable-byte wrap; it does not cover FF/home or a BS/CR that keeps the row.
  - LINECLR writes FILL to the 32 cells {new_row,0..31} over 32 cycles with ram_we=1, then returns to IDLE.
  - in_ready=0 and busy=1 during LINECLR.
  - On a wrapping printable byte, the character write happens first, then LINECLR starts.
- Undefined: the LINECLR state does not exist. Rows keep their old contents and in_ready stays 1 across row changes.

Test Plan:
1. Release reset -> exactly 1024 consecutive cycles of ram_we=1, addr 0..1023, din=0x00 with in_ready=0 and busy=1; then in_ready=1, cursor (0,0).
2. Send 0x41 then 0x42 on consecutive cycles -> writes (addr 0, 0x41) then (addr 1, 0x42) on consecutive cycles; cursor_col=2.
3. Send 33 printable bytes from home -> 33rd write lands at addr 32 (row 1, col 0). After 1024 bytes total, the next write lands at addr 0.
4. Control codes:
   - At (3,5) send 0x08 -> (3,4), no write.
   - Send 0x0D -> (3,0).
   - At row 31 send 0x0A -> (0,0).
   - At col 0 send 0x08 -> unchanged.
5. Send 0x0C at (10,7) with in_valid held high afterwards -> 1024 FILL writes, cursor (0,0), and the next byte is written to addr 0 only after the clear completes. Assert reset when the clear reaches addr 300 -> the clear restarts at addr 0.
6. With TEXT_RAM_WRITER_LINE_CLEAR_EN, send LF at row 2 -> 32 writes of FILL to addrs 96..127 with in_ready=0, then in_ready=1. Without the macro, the same LF produces no writes.
